// File: rtl/ll_quota_arb_pkg.sv
// Shared types, defaults and the round-robin search helper for the quota arbiter.
package ll_quota_arb_pkg;

    localparam int SOURCES_DEF = 4;
    localparam int LPSZ_DEF    = 8;
    localparam int CNTW_DEF    = LPSZ_DEF + 1;
    localparam int RR_MAX      = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DLVR
    } alloc_state_t;

    // Index of the first set bit at or after ptr (wrapping modulo n), or -1 when req is empty.
    function automatic int rr_winner(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int w;
        int idx;
        w = -1;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) w = idx;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ll_quota_arb_rr.sv
// Masked round-robin picker; the pointer moves past the winner whenever a pick is consumed.
module ll_rr_arb
    import ll_quota_arb_pkg::*;
#(
    parameter int n  = 4,
    parameter int iw = (n > 1) ? $clog2(n) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [n-1:0]  req,
    input  logic          adv,
    output logic [n-1:0]  gnt,
    output logic [iw-1:0] idx,
    output logic          any
);

    logic [iw-1:0]     ptr;
    logic [RR_MAX-1:0] req_w;
    int                win;

    always_comb begin
        req_w        = '0;
        req_w[n-1:0] = req;
        win          = rr_winner(req_w, int'(ptr), n);
        any          = (win >= 0);
        idx          = any ? win[iw-1:0] : '0;
        gnt          = '0;
        if (any) gnt[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (adv && any) begin
            ptr <= (idx == iw'(n - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/ll_quota_arb.sv
// Page allocator front-end: per-source quotas, one outstanding manager request, and an
// independent single-entry return path that forwards pages back to the manager.
module ll_quota_arb
    import ll_quota_arb_pkg::*;
#(
    parameter int sources = SOURCES_DEF,
    parameter int lpsz    = LPSZ_DEF,
    parameter int cntw    = lpsz + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [cntw-1:0]         cfg_quota,
    input  logic [sources-1:0]      src_req_srdy,
    output logic [sources-1:0]      src_pg_srdy,
    input  logic [sources-1:0]      src_pg_drdy,
    output logic [lpsz-1:0]         src_pg_page,
    input  logic [sources-1:0]      src_ret_srdy,
    output logic [sources-1:0]      src_ret_drdy,
    input  logic [sources*lpsz-1:0] src_ret_page,
    output logic                    mreq_srdy,
    input  logic                    mreq_drdy,
    input  logic                    mpg_srdy,
    output logic                    mpg_drdy,
    input  logic [lpsz-1:0]         mpg_page,
    output logic                    mret_srdy,
    input  logic                    mret_drdy,
    output logic [lpsz-1:0]         mret_page,
    output logic [sources*cntw-1:0] held_cnt,
    output logic                    err_underflow
);

    localparam int IW = (sources > 1) ? $clog2(sources) : 1;

    alloc_state_t       state, state_nxt;
    logic [IW-1:0]      cur_src;
    logic [sources-1:0] cur_oh;
    logic [lpsz-1:0]    pg_page;

    logic [sources-1:0] elig;
    logic [sources-1:0] alloc_gnt;
    logic [IW-1:0]      alloc_idx;
    logic               alloc_any;
    logic               alloc_adv;

    logic [sources-1:0] ret_gnt;
    logic [IW-1:0]      ret_idx;
    logic               ret_any;
    logic               ret_load;
    logic               ret_vld;
    logic [lpsz-1:0]    ret_pg;

    logic [cntw-1:0]    cnt [sources];
    logic [sources-1:0] inc;
    logic [sources-1:0] dec;
    logic [sources-1:0] uflow;

    always_comb begin
        elig = '0;
        for (int i = 0; i < sources; i++) begin
            elig[i] = src_req_srdy[i] && (cnt[i] < cfg_quota);
        end
    end

    assign alloc_adv = (state == S_IDLE);

    ll_rr_arb #(.n(sources), .iw(IW)) u_alloc_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (elig),
        .adv     (alloc_adv),
        .gnt     (alloc_gnt),
        .idx     (alloc_idx),
        .any     (alloc_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cur_src <= '0;
            cur_oh  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && alloc_any) begin
                cur_src <= alloc_idx;
                cur_oh  <= alloc_gnt;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mreq_srdy   = 1'b0;
        mpg_drdy    = 1'b0;
        src_pg_srdy = '0;
        unique case (state)
            S_IDLE: begin
                if (alloc_any) state_nxt = S_REQ;
            end
            S_REQ: begin
                mreq_srdy = 1'b1;
                if (mreq_drdy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mpg_drdy = 1'b1;
                if (mpg_srdy) state_nxt = S_DLVR;
            end
            S_DLVR: begin
                src_pg_srdy = cur_oh;
                if (src_pg_drdy[cur_src]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The delivered page is pure data; it is only observed while src_pg_srdy is high.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && mpg_srdy) pg_page <= mpg_page;
    end

    assign src_pg_page = pg_page;

    assign ret_load = !ret_vld || mret_drdy;

    ll_rr_arb #(.n(sources), .iw(IW)) u_ret_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (src_ret_srdy),
        .adv     (ret_load),
        .gnt     (ret_gnt),
        .idx     (ret_idx),
        .any     (ret_any)
    );

    assign src_ret_drdy = ret_load ? ret_gnt : '0;
    assign mret_srdy    = ret_vld;
    assign mret_page    = ret_pg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_vld <= 1'b0;
            ret_pg  <= '0;
        end else if (ret_load) begin
            ret_vld <= ret_any;
            if (ret_any) ret_pg <= src_ret_page[ret_idx*lpsz +: lpsz];
        end
    end

    always_comb begin
        inc   = '0;
        dec   = '0;
        uflow = '0;
        for (int i = 0; i < sources; i++) begin
            inc[i]   = (state == S_DLVR) && (cur_src == IW'(i)) && src_pg_drdy[i];
            dec[i]   = src_ret_srdy[i] && src_ret_drdy[i];
            uflow[i] = dec[i] && (cnt[i] == '0);
        end
    end

    // A return against a zero count is still forwarded; only the flag records it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < sources; i++) cnt[i] <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < sources; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (|uflow) err_underflow <= 1'b1;
        end
    end

    always_comb begin
        held_cnt = '0;
        for (int i = 0; i < sources; i++) begin
            held_cnt[i*cntw +: cntw] = cnt[i];
        end
    end

endmodule

// File: tb/tb_ll_quota_arb.sv
// Directed scenarios plus a randomized run scored against a transaction-level model.
module tb_ll_quota_arb;
    import ll_quota_arb_pkg::*;

    localparam int S  = 4;
    localparam int LP = 8;
    localparam int CW = 9;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [CW-1:0]     cfg_quota;
    logic [S-1:0]      src_req_srdy;
    logic [S-1:0]      src_pg_srdy;
    logic [S-1:0]      src_pg_drdy;
    logic [LP-1:0]     src_pg_page;
    logic [S-1:0]      src_ret_srdy;
    logic [S-1:0]      src_ret_drdy;
    logic [S*LP-1:0]   src_ret_page;
    logic              mreq_srdy;
    logic              mreq_drdy;
    logic              mpg_srdy;
    logic              mpg_drdy;
    logic [LP-1:0]     mpg_page;
    logic              mret_srdy;
    logic              mret_drdy;
    logic [LP-1:0]     mret_page;
    logic [S*CW-1:0]   held_cnt;
    logic              err_underflow;

    always #5 clk = ~clk;

    ll_quota_arb #(.sources(S), .lpsz(LP), .cntw(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_quota     (cfg_quota),
        .src_req_srdy  (src_req_srdy),
        .src_pg_srdy   (src_pg_srdy),
        .src_pg_drdy   (src_pg_drdy),
        .src_pg_page   (src_pg_page),
        .src_ret_srdy  (src_ret_srdy),
        .src_ret_drdy  (src_ret_drdy),
        .src_ret_page  (src_ret_page),
        .mreq_srdy     (mreq_srdy),
        .mreq_drdy     (mreq_drdy),
        .mpg_srdy      (mpg_srdy),
        .mpg_drdy      (mpg_drdy),
        .mpg_page      (mpg_page),
        .mret_srdy     (mret_srdy),
        .mret_drdy     (mret_drdy),
        .mret_page     (mret_page),
        .held_cnt      (held_cnt),
        .err_underflow (err_underflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int i);
        return held_cnt[i*CW +: CW];
    endfunction

    // Reference round-robin: first candidate at or after ptr, wrapping.
    function automatic int ref_pick(input logic [S-1:0] cand, input int ptr);
        int j;
        for (int d = 0; d < S; d++) begin
            j = (ptr + d) % S;
            for (int b = 0; b < S; b++) begin
                if (b == j && cand[b]) return j;
            end
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_req_srdy = '0;
        src_pg_drdy  = '0;
        src_ret_srdy = '0;
        src_ret_page = '0;
        mreq_drdy    = 1'b0;
        mpg_srdy     = 1'b0;
        mpg_page     = '0;
        mret_drdy    = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Model and driver state
    int               mcnt [S];
    int               mptr;
    int               nseen;
    int               exp_src;
    logic [S-1:0]     cand;
    logic [S-1:0]     one_hot;
    logic [S-1:0]     got_src;
    logic [S-1:0]     clr;
    logic [LP-1:0]    got_q [$];
    logic [LP-1:0]    exp_q [$];
    logic [LP-1:0]    pgq [$];
    logic [LP-1:0]    retq [$];
    logic [S-1:0]     rq;
    logic [S-1:0]     rv;
    logic [LP-1:0]    rp [S];
    logic             mv;
    logic [LP-1:0]    mp;
    logic             merr;
    logic [S*CW-1:0]  mvec;
    logic [LP-1:0]    exp_pg;
    int               n_dlv;
    int               n_ret;

    initial begin
        cfg_quota = CW'(2);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mreq_srdy", 64'(mreq_srdy), 64'(0));
        chk("rst_mpg_drdy", 64'(mpg_drdy), 64'(0));
        chk("rst_src_pg_srdy", 64'(src_pg_srdy), 64'(0));
        chk("rst_src_ret_drdy", 64'(src_ret_drdy), 64'(0));
        chk("rst_mret_srdy", 64'(mret_srdy), 64'(0));
        chk("rst_held_cnt", 64'(held_cnt), 64'(0));
        chk("rst_err", 64'(err_underflow), 64'(0));
        chk("rst_state", 64'(dut.state), 64'(S_IDLE));
        do_reset();

        // Single request from source 0, zero-wait manager
        mreq_drdy    = 1'b1;
        mpg_srdy     = 1'b1;
        mpg_page     = 8'h2A;
        src_req_srdy = 4'b0001;
        cyc();
        chk("s1_mreq_c1", 64'(mreq_srdy), 64'(1));
        chk("s1_pg_c1", 64'(src_pg_srdy), 64'(0));
        cyc();
        chk("s1_mpg_drdy_c2", 64'(mpg_drdy), 64'(1));
        chk("s1_pg_c2", 64'(src_pg_srdy), 64'(0));
        cyc();
        chk("s1_pg_c3", 64'(src_pg_srdy), 64'(4'b0001));
        chk("s1_page", 64'(src_pg_page), 64'(8'h2A));
        chk("s1_mreq_c3", 64'(mreq_srdy), 64'(0));
        src_pg_drdy  = 4'b1111;
        src_req_srdy = 4'b0000;
        cyc();
        chk("s1_cnt0", 64'(cnt_of(0)), 64'(1));
        chk("s1_pg_done", 64'(src_pg_srdy), 64'(0));
        chk("s1_state", 64'(dut.state), 64'(S_IDLE));

        // All sources requesting with quota 2
        do_reset();
        cfg_quota    = CW'(2);
        src_req_srdy = 4'b1111;
        src_pg_drdy  = 4'b1111;
        mreq_drdy    = 1'b1;
        mpg_srdy     = 1'b1;
        mpg_page     = 8'h40;
        for (int i = 0; i < S; i++) mcnt[i] = 0;
        mptr  = 0;
        nseen = 0;
        for (int c = 0; c < 80 && nseen < 8; c++) begin
            if (src_pg_srdy != '0) begin
                for (int b = 0; b < S; b++) cand[b] = (mcnt[b] < 2);
                exp_src = ref_pick(cand, mptr);
                one_hot = S'(1) << exp_src;
                chk($sformatf("s2_grant%0d", nseen), 64'(src_pg_srdy), 64'(one_hot));
                mcnt[exp_src]++;
                mptr = (exp_src + 1) % S;
                nseen++;
            end
            cyc();
        end
        chk("s2_ngrants", 64'(nseen), 64'(8));
        repeat (6) cyc();
        chk("s2_no_mreq", 64'(mreq_srdy), 64'(0));
        chk("s2_state", 64'(dut.state), 64'(S_IDLE));
        for (int i = 0; i < S; i++) chk($sformatf("s2_cnt%0d", i), 64'(cnt_of(i)), 64'(mcnt[i]));

        // Source 1 at quota returns page 5 while requesting
        src_req_srdy = 4'b0010;
        src_ret_srdy = 4'b0010;
        src_ret_page = 32'h0000_0500;
        mret_drdy    = 1'b0;
        #1;
        chk("s3_ret_drdy", 64'(src_ret_drdy), 64'(4'b0010));
        cyc();
        src_ret_srdy = 4'b0000;
        chk("s3_mret_srdy", 64'(mret_srdy), 64'(1));
        chk("s3_mret_page", 64'(mret_page), 64'(8'h05));
        chk("s3_cnt1_dec", 64'(cnt_of(1)), 64'(1));
        got_src = '0;
        for (int c = 0; c < 20 && got_src == '0; c++) begin
            if (src_pg_srdy != '0) got_src = src_pg_srdy;
            else cyc();
        end
        chk("s3_regrant", 64'(got_src), 64'(4'b0010));
        cyc();
        src_req_srdy = 4'b0000;
        chk("s3_cnt1_inc", 64'(cnt_of(1)), 64'(2));
        mret_drdy = 1'b1;
        cyc();
        chk("s3_ret_drained", 64'(mret_srdy), 64'(0));
        mret_drdy = 1'b0;

        // Underflow on source 2
        do_reset();
        chk("s4_err_clear", 64'(err_underflow), 64'(0));
        mret_drdy    = 1'b1;
        src_ret_srdy = 4'b0100;
        src_ret_page = 32'h0077_0000;
        #1;
        chk("s4_ret_drdy", 64'(src_ret_drdy), 64'(4'b0100));
        cyc();
        src_ret_srdy = 4'b0000;
        chk("s4_err", 64'(err_underflow), 64'(1));
        chk("s4_cnt2", 64'(cnt_of(2)), 64'(0));
        chk("s4_fwd_vld", 64'(mret_srdy), 64'(1));
        chk("s4_fwd_page", 64'(mret_page), 64'(8'h77));
        cyc();
        chk("s4_err_sticky", 64'(err_underflow), 64'(1));
        chk("s4_fwd_done", 64'(mret_srdy), 64'(0));
        mret_drdy = 1'b0;

        // Reset asserted while waiting for the manager page
        do_reset();
        src_req_srdy = 4'b0001;
        mreq_drdy    = 1'b1;
        cyc();
        cyc();
        chk("s5_in_wait", 64'(mpg_drdy), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("s5_async_mpg_drdy", 64'(mpg_drdy), 64'(0));
        chk("s5_async_mreq", 64'(mreq_srdy), 64'(0));
        chk("s5_async_state", 64'(dut.state), 64'(S_IDLE));
        src_req_srdy = 4'b0000;
        mpg_srdy     = 1'b1;
        mpg_page     = 8'h99;
        cyc();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("s5_no_dlv%0d", c), 64'(src_pg_srdy), 64'(0));
            chk($sformatf("s5_no_req%0d", c), 64'(mreq_srdy), 64'(0));
        end
        chk("s5_cnts", 64'(held_cnt), 64'(0));
        chk("s5_state", 64'(dut.state), 64'(S_IDLE));
        mpg_srdy = 1'b0;

        // Three returns pending while the manager stalls
        do_reset();
        src_ret_srdy = 4'b1011;
        src_ret_page = 32'h1300_1110;
        mret_drdy    = 1'b0;
        exp_q.delete();
        cand = 4'b1011;
        mptr = 0;
        while (cand != '0) begin
            exp_src = ref_pick(cand, mptr);
            exp_q.push_back(src_ret_page[exp_src*LP +: LP]);
            cand[exp_src] = 1'b0;
            mptr = (exp_src + 1) % S;
        end
        #1;
        chk("s6_first_drdy", 64'(src_ret_drdy), 64'(4'b0001));
        cyc();
        src_ret_srdy = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("s6_stall_drdy%0d", k), 64'(src_ret_drdy), 64'(0));
            chk($sformatf("s6_stall_vld%0d", k), 64'(mret_srdy), 64'(1));
            chk($sformatf("s6_stall_page%0d", k), 64'(mret_page), 64'(exp_q[0]));
            cyc();
        end
        mret_drdy = 1'b1;
        got_q.delete();
        for (int c = 0; c < 20 && got_q.size() < 3; c++) begin
            #1;
            if (mret_srdy && mret_drdy) got_q.push_back(mret_page);
            clr = src_ret_srdy & src_ret_drdy;
            cyc();
            src_ret_srdy = src_ret_srdy & ~clr;
        end
        chk("s6_ndrained", 64'(got_q.size()), 64'(3));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s6_order%0d", k), 64'((k < got_q.size()) ? got_q[k] : 8'hFF), 64'(exp_q[k]));
        end
        chk("s6_err", 64'(err_underflow), 64'(1));
        mret_drdy = 1'b0;

        // Zero quota blocks every source
        do_reset();
        cfg_quota    = CW'(0);
        src_req_srdy = 4'b1111;
        mreq_drdy    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk($sformatf("q0_no_mreq%0d", c), 64'(mreq_srdy), 64'(0));
        end

        // Randomized traffic against the transaction-level model
        do_reset();
        cfg_quota = CW'($urandom_range(1, 3));
        for (int i = 0; i < S; i++) begin
            mcnt[i] = 0;
            rp[i]   = '0;
        end
        rq = '0;
        rv = '0;
        mv = 1'b0;
        mp = '0;
        merr = 1'b0;
        pgq.delete();
        retq.delete();
        n_dlv = 0;
        n_ret = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) cfg_quota = CW'(1);
            for (int i = 0; i < S; i++) begin
                if (!rq[i] && $urandom_range(0, 3) == 0) rq[i] = 1'b1;
                if (!rv[i] && mcnt[i] > 0 && $urandom_range(0, 5) == 0) begin
                    rv[i] = 1'b1;
                    rp[i] = LP'($urandom);
                end
                src_ret_page[i*LP +: LP] = rp[i];
            end
            if (!mv && $urandom_range(0, 1) == 1) begin
                mv = 1'b1;
                mp = LP'($urandom);
            end
            src_req_srdy = rq;
            src_ret_srdy = rv;
            mpg_srdy     = mv;
            mpg_page     = mp;
            mreq_drdy    = 1'($urandom_range(0, 1));
            mret_drdy    = ($urandom_range(0, 2) != 0);
            src_pg_drdy  = S'($urandom);
            #1;
            for (int i = 0; i < S; i++) mvec[i*CW +: CW] = CW'(mcnt[i]);
            chk("rnd_held_cnt", 64'(held_cnt), 64'(mvec));
            chk("rnd_err", 64'(err_underflow), 64'(merr));
            chk("rnd_pg_onehot", 64'($onehot0(src_pg_srdy)), 64'(1));
            chk("rnd_ret_onehot", 64'($onehot0(src_ret_drdy)), 64'(1));
            chk("rnd_pg_to_requester", 64'(src_pg_srdy & ~rq), 64'(0));
            if (mret_srdy && mret_drdy) begin
                chk("rnd_ret_avail", 64'(retq.size() != 0), 64'(1));
                if (retq.size() != 0) begin
                    exp_pg = retq.pop_front();
                    chk("rnd_mret_page", 64'(mret_page), 64'(exp_pg));
                end
            end
            if (mpg_srdy && mpg_drdy) begin
                pgq.push_back(mpg_page);
                mv = 1'b0;
            end
            for (int i = 0; i < S; i++) begin
                if (src_pg_srdy[i] && src_pg_drdy[i]) begin
                    chk("rnd_pg_avail", 64'(pgq.size() != 0), 64'(1));
                    if (pgq.size() != 0) begin
                        exp_pg = pgq.pop_front();
                        chk("rnd_pg_page", 64'(src_pg_page), 64'(exp_pg));
                    end
                    mcnt[i]++;
                    rq[i] = 1'b0;
                    n_dlv++;
                end
            end
            for (int i = 0; i < S; i++) begin
                if (src_ret_srdy[i] && src_ret_drdy[i]) begin
                    retq.push_back(rp[i]);
                    if (mcnt[i] == 0) merr = 1'b1;
                    else mcnt[i]--;
                    rv[i] = 1'b0;
                    n_ret++;
                end
            end
            cyc();
        end
        chk("rnd_deliveries", 64'(n_dlv > 50), 64'(1));
        chk("rnd_returns", 64'(n_ret > 20), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
